bcd_mod_counter: RTL

//  Parametrised synchronous BCD counter, modulus MODULUS, DIGITS packed BCD digits.

---
 rtl/bcd_mod_counter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/bcd_mod_counter.sv
// Parametrised packed-BCD modulo counter with enable, up/down counting, validated parallel load
// and one-cycle carry/borrow/load-error pulses for cascading stages.
module bcd_mod_counter #(
    parameter int DIGITS  = 2,
    parameter int MODULUS = 60
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  up_dn,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count,
    output logic                  carry,
    output logic                  borrow,
    output logic                  load_err
);

    localparam int W = 4 * DIGITS;

    function automatic logic [W-1:0] to_bcd(input int value);
        logic [W-1:0] res;
        int           v;
        res = {W{1'b0}};
        v   = value;
        for (int d = 0; d < DIGITS; d++) begin
            res[4*d +: 4] = 4'(v % 32'd10);
            v             = v / 32'd10;
        end
        return res;
    endfunction

    // Terminal count, fixed at elaboration so the datapath only compares BCD patterns.
    localparam logic [W-1:0] MAX_BCD = to_bcd(MODULUS - 1);

    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
        logic [W-1:0] res;
        logic         c;
        res = v;
        c   = 1'b1;
        for (int d = 0; d < DIGITS; d++) begin
            if (c) begin
                if (v[4*d +: 4] == 4'd9) begin
                    res[4*d +: 4] = 4'd0;
                end else begin
                    res[4*d +: 4] = v[4*d +: 4] + 4'd1;
                    c             = 1'b0;
                end
            end else begin
                res[4*d +: 4] = v[4*d +: 4];
            end
        end
        return res;
    endfunction

    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] res;
        logic         b;
        res = v;
        b   = 1'b1;
        for (int d = 0; d < DIGITS; d++) begin
            if (b) begin
                if (v[4*d +: 4] == 4'd0) begin
                    res[4*d +: 4] = 4'd9;
                end else begin
                    res[4*d +: 4] = v[4*d +: 4] - 4'd1;
                    b             = 1'b0;
                end
            end else begin
                res[4*d +: 4] = v[4*d +: 4];
            end
        end
        return res;
    endfunction

    // Legal BCD orders numerically like its decimal value, so a plain compare bounds the range.
    function automatic logic bcd_valid(input logic [W-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int d = 0; d < DIGITS; d++) begin
            if (v[4*d +: 4] > 4'd9) begin
                ok = 1'b0;
            end else begin
                ok = ok;
            end
        end
        return ok && (v <= MAX_BCD);
    endfunction

    logic [W-1:0] r_count;
    logic         r_carry;
    logic         r_borrow;
    logic         r_load_err;

    logic [W-1:0] w_next_count;
    logic         w_carry;
    logic         w_borrow;
    logic         w_load_err;
    logic         w_load_ok;

    assign w_load_ok = bcd_valid(load_val);

    // Next-state selection: load beats enable beats hold.
    always_comb begin
        w_next_count = r_count;
        w_carry      = 1'b0;
        w_borrow     = 1'b0;
        w_load_err   = 1'b0;
        if (load) begin
            if (w_load_ok) begin
                w_next_count = load_val;
            end else begin
                w_load_err = 1'b1;
            end
        end else if (en) begin
            if (up_dn) begin
                if (r_count == MAX_BCD) begin
                    w_next_count = {W{1'b0}};
                    w_carry      = 1'b1;
                end else begin
                    w_next_count = bcd_inc(r_count);
                end
            end else begin
                if (r_count == {W{1'b0}}) begin
                    w_next_count = MAX_BCD;
                    w_borrow     = 1'b1;
                end else begin
                    w_next_count = bcd_dec(r_count);
                end
            end
        end else begin
            w_next_count = r_count;
        end
    end

    // State and pulse registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count    <= {W{1'b0}};
            r_carry    <= 1'b0;
            r_borrow   <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_count    <= w_next_count;
            r_carry    <= w_carry;
            r_borrow   <= w_borrow;
            r_load_err <= w_load_err;
        end
    end

    assign count    = r_count;
    assign carry    = r_carry;
    assign borrow   = r_borrow;
    assign load_err = r_load_err;

endmodule
